// File: rtl/m4_frame_pkg.sv
// Shared types and frame-map constants for the M4 word stream.
package m4_frame_pkg;

   localparam int FRAME_LEN  = 512;
   localparam int SUB_PERIOD = 16;
   localparam int SUB_OFFSET = 2;
   localparam int GRP_POS    = 149;
   localparam logic [11:0] FILL_WORD = 12'h002;

   typedef enum logic [1:0] {W_FRAME, W_SUB, W_GRP, W_FILL} word_type_e;

   typedef enum logic {HUNT, LOCKED} state_e;

endpackage

// File: rtl/m4_word_classify.sv
// Maps a frame position to the kind of word the M4 frame map puts there.
module m4_word_classify
   import m4_frame_pkg::*;
(
   input  logic [8:0]  pos,
   output word_type_e  word_type
);

   // Position 0 takes precedence; GRP_POS never lands on a subframe slot.
   always_comb begin
      word_type = W_FILL;
      if (pos == 9'd0)
         word_type = W_FRAME;
      else if ((int'(pos) % SUB_PERIOD) == SUB_OFFSET)
         word_type = W_SUB;
      else if (int'(pos) == GRP_POS)
         word_type = W_GRP;
   end

endmodule

// File: rtl/m4_frame_checker.sv
// M4 frame checker: finds alignment on the 12-bit word stream and checks
// every word against the fixed frame map while locked.
//
//   state  | meaning
//   HUNT   | no alignment; shifting words looking for pos0/fill/pos2 pattern
//   LOCKED | aligned; every word checked against the frame map
module m4_frame_checker
   import m4_frame_pkg::*;
#(
   parameter int LOSS_LIMIT = 3
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        wordValid,
   input  logic [11:0] dataWord,
   output logic        locked,
   output logic        frameStrobe,
   output logic        errPulse,
   output logic [15:0] errCount,
   output logic [8:0]  frameNum,
   output logic [9:0]  grpNum
);

   localparam int MISS_W = $clog2(LOSS_LIMIT + 1);

   state_e             state, state_nx;
   logic               run;
   logic               accept;
   logic [8:0]         pos, pos_nx, pos_in;
   logic [11:0]        hist2, hist2_nx, hist1, hist1_nx;
   logic [8:0]         fref, fref_nx;
   logic [7:0]         sref, sref_nx;
   logic [9:0]         gref, gref_nx;
   logic               gseen, gseen_nx;
   logic [MISS_W-1:0]  miss, miss_nx;
   logic               strobe_nx, err_nx;
   logic [15:0]        err_count_nx;
   logic [8:0]         frame_num_nx;
   logic [9:0]         grp_num_nx;
   logic               mismatch, drop;
   word_type_e         word_type;

   // A word arriving on the first edge after reset release is dropped.
   assign accept = wordValid & run;
   assign pos_in = (int'(pos) == FRAME_LEN - 1) ? 9'd0 : pos + 9'd1;
   assign locked = (state == LOCKED);

   m4_word_classify u_classify (
      .pos       (pos_in),
      .word_type (word_type)
   );

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= HUNT;
         run         <= 1'b0;
         pos         <= '0;
         hist2       <= '0;
         hist1       <= '0;
         fref        <= '0;
         sref        <= '0;
         gref        <= '0;
         gseen       <= 1'b0;
         miss        <= '0;
         frameStrobe <= 1'b0;
         errPulse    <= 1'b0;
         errCount    <= '0;
         frameNum    <= '0;
         grpNum      <= '0;
      end else begin
         state       <= state_nx;
         run         <= 1'b1;
         pos         <= pos_nx;
         hist2       <= hist2_nx;
         hist1       <= hist1_nx;
         fref        <= fref_nx;
         sref        <= sref_nx;
         gref        <= gref_nx;
         gseen       <= gseen_nx;
         miss        <= miss_nx;
         frameStrobe <= strobe_nx;
         errPulse    <= err_nx;
         errCount    <= err_count_nx;
         frameNum    <= frame_num_nx;
         grpNum      <= grp_num_nx;
      end
   end

   // Next-state: pattern hunt, then per-word map check with reference reload.
   always_comb begin
      state_nx     = state;
      pos_nx       = pos;
      hist2_nx     = hist2;
      hist1_nx     = hist1;
      fref_nx      = fref;
      sref_nx      = sref;
      gref_nx      = gref;
      gseen_nx     = gseen;
      miss_nx      = miss;
      strobe_nx    = 1'b0;
      err_nx       = 1'b0;
      err_count_nx = errCount;
      frame_num_nx = frameNum;
      grp_num_nx   = grpNum;
      mismatch     = 1'b0;
      drop         = 1'b0;
      if (accept) begin
         unique case (state)
            HUNT: begin
               hist2_nx = hist1;
               hist1_nx = dataWord;
               if (hist2[2:0] == 3'b001 && hist1 == FILL_WORD && dataWord[2:0] == 3'b001) begin
                  state_nx     = LOCKED;
                  pos_nx       = 9'd2;
                  sref_nx      = dataWord[10:3];
                  fref_nx      = hist2[11:3];
                  frame_num_nx = hist2[11:3];
                  gseen_nx     = 1'b0;
                  miss_nx      = '0;
               end
            end
            LOCKED: begin
               pos_nx = pos_in;
               unique case (word_type)
                  W_FRAME: begin
                     mismatch     = (dataWord[2:0] != 3'b001) || (dataWord[11:3] != fref + 9'd1);
                     fref_nx      = dataWord[11:3];
                     frame_num_nx = dataWord[11:3];
                     if (mismatch) begin
                        if (int'(miss) + 1 >= LOSS_LIMIT)
                           drop = 1'b1;
                        else
                           miss_nx = miss + MISS_W'(1);
                     end else begin
                        miss_nx = '0;
                     end
                     strobe_nx = !drop;
                  end
                  W_SUB: begin
                     mismatch = dataWord[11] || (dataWord[2:0] != 3'b001) ||
                                (dataWord[10:3] != sref + 8'd1);
                     sref_nx  = dataWord[10:3];
                  end
                  W_GRP: begin
                     // First group word after lock only seeds the reference.
                     mismatch   = gseen && (dataWord[11] || dataWord[0] ||
                                  (dataWord[10:1] != gref && dataWord[10:1] != gref + 10'd1));
                     gref_nx    = dataWord[10:1];
                     gseen_nx   = 1'b1;
                     grp_num_nx = dataWord[10:1];
                  end
                  W_FILL: begin
                     mismatch = (dataWord != FILL_WORD);
                  end
               endcase
               if (mismatch) begin
                  err_nx = 1'b1;
                  if (errCount != 16'hFFFF)
                     err_count_nx = errCount + 16'd1;
               end
               if (drop) begin
                  state_nx = HUNT;
                  pos_nx   = '0;
                  miss_nx  = '0;
                  hist2_nx = '0;
                  hist1_nx = '0;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/m4_frame_checker.md
Name: m4_frame_checker

Overview:
- Receive-side counterpart of the M4 word filler: consumes the 12-bit M4 word stream, finds frame alignment, and checks every word against the fixed frame map (frame counter, subframe counter, group counter, filler).
- Sits at the demultiplexer/loopback output of the M16 imitator test path and reports lock, decoded counters and an error count for bench and field self-test.

Parameters:
- FRAME_LEN, 512, words per frame; the position counter wraps at FRAME_LEN-1.
- SUB_PERIOD, 16, spacing of subframe-counter words.
- SUB_OFFSET, 2, position of the first subframe-counter word.
- GRP_POS, 149, position of the group-counter word.
- FILL_WORD, 12'h002, value of every non-marker word.
- LOSS_LIMIT, 3, consecutive bad frame-counter words before lock is dropped.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wordValid  in  1  one-cycle strobe; dataWord is valid in this cycle.
- dataWord  in  12  received M4 word.
- locked  out  1  frame alignment is held.
- frameStrobe  out  1  one-cycle pulse when the position-0 word is accepted while locked.
- errPulse  out  1  one-cycle pulse on any mismatch while locked.
- errCount  out  16  saturating mismatch count.
- frameNum  out  9  last received frame counter.
- grpNum  out  10  last received group counter.

Behaviour:
- Word formats:
  - Position 0: {cnt[8:0], 3'b001}.
  - Subframe positions (pos % SUB_PERIOD == SUB_OFFSET): {1'b0, cnt[7:0], 3'b001}.
  - GRP_POS: {1'b0, cnt[9:0], 1'b0}.
  - All other positions: FILL_WORD.
- Timing and reset:
  - All state advances only on cycles with wordValid=1.
  - Outputs are registered, so there is 1 clk latency from the accepting edge.
  - Reset clears every output and register to 0 and the FSM to HUNT. Reset asserted mid-frame discards alignment immediately.
- FSM HUNT:
  - Shift the last 3 words.
  - Pattern [n-2][2:0]==3'b001, [n-1]==FILL_WORD, [n][2:0]==3'b001 marks the current word as position 2. This pattern is unique within the frame map.
  - On the pattern, set pos=2 and go to LOCKED with seed flags set.
  - Seed the subframe reference from the current word.
  - Seed the frame reference from word n-2, so frameNum is valid.
- FSM LOCKED:
  - pos increments per valid word and wraps FRAME_LEN-1 -> 0.
  - Each word is compared against the map:
    - Frame counter: must equal ref+1 mod 512.
    - Subframe counter: must equal ref+1 mod 256; it runs continuously across frames, 32 steps per frame.
    - Group counter: must equal ref or ref+1 mod 1024. It accepts and loads without a check on the first occurrence after lock.
    - Filler: exact match to FILL_WORD.
  - After every check, the reference register loads the received value, so a single corrupted counter costs at most 2 errors.
  - Each mismatch pulses errPulse and increments errCount, which saturates at 16'hFFFF.
  - A position-0 mismatch increments the miss counter; a position-0 match clears it.
  - Reaching LOSS_LIMIT misses drops to HUNT: locked=0, pos cleared, no frameStrobe. errCount is retained.
- Simultaneous events:
  - Pattern detection is ignored while LOCKED.
  - A wordValid on the same edge as reset release is ignored.
- Counter outputs: frameNum and grpNum update on every accepted counter word, matching or not.

Decomposition:
- Package m4_frame_pkg: word-type enum (W_FRAME, W_SUB, W_GRP, W_FILL), FSM state enum (HUNT, LOCKED), default constants FILL_WORD, GRP_POS, SUB_PERIOD, SUB_OFFSET.
- One sub-module m4_word_classify: combinational, maps pos to word type. Shared with future generators.

Test Plan:
- Clean stream of 3 frames starting mid-frame at pos 300 -> locked rises 1 clk after pos-2 word of the first full frame; frameStrobe once per frame; errCount=0; frameNum tracks 5,6,7 when the source frame counter starts at 4.
- Filler at pos 40 corrupted to 12'h006 -> single errPulse, errCount=1, lock held.
- Subframe word at pos 18 carries cnt+2 -> errCount=2 (that word, then the next subframe word relative to the corrupted reference), lock held.
- Group word steady at 10'd7 for 2 frames, then 8, then 10 -> no error for 7->7 and 7->8, one error for 8->10.
- Position-0 word corrupted in 3 consecutive frames -> locked drops after the third; re-locks on the next clean frame; errCount retained.
- reset pulled low at pos 200 while locked -> all outputs 0 asynchronously; after release, HUNT, then re-lock on the next frame start.
